// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command sequencer behind the SPI_slave byte interface.
// Each chip-select framed stream is parsed as [cmd][data...]; cmd bit7 selects
// read (1) or write (0), cmd bits 6:0 give the start address. Data bytes access
// an internal bank of NUM_REGS 8-bit registers with optional auto-increment.
// Address 0x7F reads back ID_VALUE, which is also the first MISO byte of a frame.
module spi_reg_ctrl #(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ssel_active,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  busy,
  output logic                  frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WRITE,
    READ
  } state_t;

  localparam logic [6:0] ADDR_ID   = 7'h7F;
  localparam logic [6:0] ADDR_STEP = AUTO_INC ? 7'd1 : 7'd0;

  state_t     state;
  state_t     state_next;
  logic [7:0] regs [NUM_REGS];
  logic [6:0] addr;
  logic       ssel_prev;
  logic       ssel_rise;

  logic       frame_start;
  logic       cmd_take;
  logic       data_wr;
  logic       data_rd;

  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_bad;
  logic       wr_hit;

  function automatic logic in_bank(input logic [6:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  // Chip-select history: sampled even during reset so that a select already
  // asserted across reset is not mistaken for a new frame afterwards.
  always_ff @(posedge clk) begin
    ssel_prev <= ssel_active;
  end

  assign ssel_rise = ssel_active && !ssel_prev;

  // Next-state and per-cycle action decode.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    cmd_take    = 1'b0;
    data_wr     = 1'b0;
    data_rd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ssel_rise) begin
          state_next  = CMD;
          frame_start = 1'b1;
        end
      end
      CMD: begin
        if (rx_valid) begin
          cmd_take   = 1'b1;
          state_next = rx_byte[7] ? READ : WRITE;
        end
      end
      WRITE: data_wr = rx_valid;
      READ:  data_rd = rx_valid;
      default: state_next = IDLE;
    endcase
    // A byte completing on the same cycle select drops is still handled above;
    // only the state returns to IDLE.
    if (state != IDLE && !ssel_active) begin
      state_next = IDLE;
    end
  end

  // Register read mux: the command byte supplies the address directly, data
  // bytes use the running address.
  always_comb begin
    rd_addr = cmd_take ? rx_byte[6:0] : addr;
    rd_data = '0;
    rd_bad  = 1'b0;
    if (in_bank(rd_addr)) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (rd_addr == 7'(i)) rd_data = regs[i];
      end
    end else if (rd_addr == ADDR_ID) begin
      rd_data = ID_VALUE;
    end else begin
      rd_bad = 1'b1;
    end
  end

  assign wr_hit = in_bank(addr);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address, MISO byte, write strobe and error flag updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      tx_byte   <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      wr_strobe <= 1'b0;
      if (frame_start) begin
        tx_byte   <= ID_VALUE;
        frame_err <= 1'b0;
      end
      if (cmd_take) begin
        if (rx_byte[7]) begin
          tx_byte <= rd_data;
          addr    <= rx_byte[6:0] + ADDR_STEP;
          if (rd_bad) frame_err <= 1'b1;
        end else begin
          addr <= rx_byte[6:0];
        end
      end
      if (data_wr) begin
        if (wr_hit) begin
          wr_strobe <= 1'b1;
          wr_addr   <= addr;
        end else begin
          frame_err <= 1'b1;
        end
        addr <= addr + ADDR_STEP;
      end
      if (data_rd) begin
        tx_byte <= rd_data;
        addr    <= addr + ADDR_STEP;
        if (rd_bad) frame_err <= 1'b1;
      end
    end
  end

  // Register bank storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (data_wr && wr_hit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (addr == 7'(i)) regs[i] <= rx_byte;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule
